// File: rtl/pokey_bus_sequencer.sv
// CPU-side bus master for one POKEY: generates phi2 and chip-select timing, runs the
// SKCTL/AUDCTL init writes, then round-robin shares the bus between two requesters.
module pokey_bus_sequencer #(
    parameter int unsigned PHI_HALF    = 28,
    parameter logic [7:0]  INIT_SKCTL  = 8'h03,
    parameter logic [7:0]  INIT_AUDCTL = 8'h00
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       req0_valid,
    input  logic       req0_rw,
    input  logic [3:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rw,
    input  logic [3:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       rd_port,
    output logic [7:0] pokey_din,
    input  logic [7:0] pokey_dout,
    output logic [3:0] pokey_a,
    output logic       pokey_phi2,
    output logic       pokey_rw,
    output logic       pokey_cs0_bar,
    output logic       init_done,
    output logic       busy
);

    localparam int unsigned Period = 2 * PHI_HALF;
    localparam int unsigned PhW    = $clog2(Period);
    localparam logic [PhW-1:0] PhaseHalf = PhW'(PHI_HALF);
    localparam logic [PhW-1:0] PhaseLast = PhW'(Period - 1);

    typedef enum logic [1:0] {StInitSk, StInitAc, StRun} state_e;

    state_e         state_q, state_d;
    logic [PhW-1:0] phase_q, phase_d;
    logic           phi2_q, phi2_d;
    logic           cs0_bar_q, cs0_bar_d;
    logic           rw_q, rw_d;
    logic [3:0]     a_q, a_d;
    logic [7:0]     din_q, din_d;
    logic           ready0_q, ready0_d;
    logic           ready1_q, ready1_d;
    logic [7:0]     rd_data_q, rd_data_d;
    logic           rd_valid_q, rd_valid_d;
    logic           rd_port_q, rd_port_d;
    logic           init_done_q, init_done_d;
    logic           busy_q, busy_d;
    logic           last_grant_q, last_grant_d;
    logic           rd_pend_q, rd_pend_d;
    logic           cur_port_q, cur_port_d;
    logic           grant0, grant1;

    // Both valid: the port that did not win last time gets the bus.
    assign grant0 = req0_valid & (~req1_valid | last_grant_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

    // phase_q runs one step ahead of the bus outputs, so registers loaded while
    // phase_q == 0 become visible together with bus phase 0.
    always_comb begin
        phase_d      = (phase_q == PhaseLast) ? '0 : phase_q + 1'b1;
        phi2_d       = (phase_q >= PhaseHalf);
        state_d      = state_q;
        cs0_bar_d    = cs0_bar_q;
        rw_d         = rw_q;
        a_d          = a_q;
        din_d        = din_q;
        ready0_d     = 1'b0;
        ready1_d     = 1'b0;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        rd_port_d    = rd_port_q;
        init_done_d  = init_done_q;
        busy_d       = busy_q;
        last_grant_d = last_grant_q;
        rd_pend_d    = rd_pend_q;
        cur_port_d   = cur_port_q;

        if (phase_q == '0) begin
            if (rd_pend_q) begin
                rd_data_d  = pokey_dout;
                rd_valid_d = 1'b1;
                rd_port_d  = cur_port_q;
            end
            cs0_bar_d = 1'b1;
            rw_d      = 1'b1;
            busy_d    = 1'b0;
            rd_pend_d = 1'b0;
            unique case (state_q)
                StInitSk: begin
                    cs0_bar_d = 1'b0;
                    rw_d      = 1'b0;
                    a_d       = 4'hF;
                    din_d     = INIT_SKCTL;
                    busy_d    = 1'b1;
                    state_d   = StInitAc;
                end
                StInitAc: begin
                    cs0_bar_d = 1'b0;
                    rw_d      = 1'b0;
                    a_d       = 4'h8;
                    din_d     = INIT_AUDCTL;
                    busy_d    = 1'b1;
                    state_d   = StRun;
                end
                StRun: begin
                    init_done_d = 1'b1;
                    if (grant0 || grant1) begin
                        cs0_bar_d    = 1'b0;
                        busy_d       = 1'b1;
                        rw_d         = grant1 ? req1_rw : req0_rw;
                        a_d          = grant1 ? req1_addr : req0_addr;
                        din_d        = grant1 ? req1_data : req0_data;
                        rd_pend_d    = grant1 ? req1_rw : req0_rw;
                        cur_port_d   = grant1;
                        last_grant_d = grant1;
                        ready0_d     = grant0;
                        ready1_d     = grant1;
                    end
                end
                default: state_d = StInitSk;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= StInitSk;
            phase_q      <= '0;
            phi2_q       <= 1'b0;
            cs0_bar_q    <= 1'b1;
            rw_q         <= 1'b1;
            a_q          <= '0;
            din_q        <= '0;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_port_q    <= 1'b0;
            init_done_q  <= 1'b0;
            busy_q       <= 1'b0;
            last_grant_q <= 1'b1;
            rd_pend_q    <= 1'b0;
            cur_port_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            phi2_q       <= phi2_d;
            cs0_bar_q    <= cs0_bar_d;
            rw_q         <= rw_d;
            a_q          <= a_d;
            din_q        <= din_d;
            ready0_q     <= ready0_d;
            ready1_q     <= ready1_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            rd_port_q    <= rd_port_d;
            init_done_q  <= init_done_d;
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            rd_pend_q    <= rd_pend_d;
            cur_port_q   <= cur_port_d;
        end
    end

    assign req0_ready    = ready0_q;
    assign req1_ready    = ready1_q;
    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign rd_port       = rd_port_q;
    assign pokey_din     = din_q;
    assign pokey_a       = a_q;
    assign pokey_phi2    = phi2_q;
    assign pokey_rw      = rw_q;
    assign pokey_cs0_bar = cs0_bar_q;
    assign init_done     = init_done_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_pokey_bus_sequencer.sv
// Scoreboard bench for pokey_bus_sequencer: a cycle-level reference model predicts bus
// pins and pushes expected ready/read events; a monitor pops them as the DUT emits them.
module tb_pokey_bus_sequencer;

    localparam int PH = 28;
    localparam int P  = 2 * PH;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       req0_valid = 1'b0, req0_rw = 1'b0;
    logic [3:0] req0_addr = '0;
    logic [7:0] req0_data = '0;
    logic       req1_valid = 1'b0, req1_rw = 1'b0;
    logic [3:0] req1_addr = '0;
    logic [7:0] req1_data = '0;
    logic [7:0] pokey_dout = '0;
    logic       req0_ready, req1_ready, rd_valid, rd_port;
    logic [7:0] rd_data, pokey_din;
    logic [3:0] pokey_a;
    logic       pokey_phi2, pokey_rw, pokey_cs0_bar, init_done, busy;

    pokey_bus_sequencer #(.PHI_HALF(PH)) dut (
        .clk(clk), .clr(clr),
        .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_ready(req1_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_port(rd_port),
        .pokey_din(pokey_din), .pokey_dout(pokey_dout), .pokey_a(pokey_a),
        .pokey_phi2(pokey_phi2), .pokey_rw(pokey_rw), .pokey_cs0_bar(pokey_cs0_bar),
        .init_done(init_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic rw; logic [3:0] addr; logic [7:0] data; int delay; } req_t;
    typedef struct { int cyc; int kind; int port; int data; } ev_t; // kind 0/1 ready, 2 read

    req_t q0[$];
    req_t q1[$];
    ev_t  exq[$];
    int   nvec = 0;
    int   nfail = 0;
    int   cyc = -1;   // cycles since the first clock edge with clr low
    bit   m_rd_pend = 0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int port, input logic rw, input logic [3:0] addr,
                        input logic [7:0] data, input int delay);
        req_t r;
        r.rw = rw; r.addr = addr; r.data = data; r.delay = delay;
        if (port == 0) q0.push_back(r); else q1.push_back(r);
    endtask

    // Requesters: present the head request after its delay, hold it until ready.
    initial begin
        int w0 = 0, w1 = 0;
        forever begin
            @(posedge clk);
            #1;
            if (req0_valid && req0_ready) begin q0.delete(0); req0_valid = 1'b0; w0 = 0; end
            if (req1_valid && req1_ready) begin q1.delete(0); req1_valid = 1'b0; w1 = 0; end
            if (!req0_valid && q0.size() > 0) begin
                if (w0 >= q0[0].delay) begin
                    req0_valid = 1'b1; req0_rw = q0[0].rw;
                    req0_addr = q0[0].addr; req0_data = q0[0].data;
                end else w0++;
            end
            if (!req1_valid && q1.size() > 0) begin
                if (w1 >= q1[0].delay) begin
                    req1_valid = 1'b1; req1_rw = q1[0].rw;
                    req1_addr = q1[0].addr; req1_data = q1[0].data;
                end else w1++;
            end
            pokey_dout = 8'($urandom);
        end
    end

    // Reference model: bus transactions begin every P cycles; period k=0 SKCTL, k=1
    // AUDCTL, later periods serve requesters with round-robin on ties.
    initial begin
        logic s_clr, s_v0, s_v1, s_rw0, s_rw1;
        logic [3:0] s_a0, s_a1;
        logic [7:0] s_d0, s_d1, s_dout;
        int e_cs0 = 1, e_rw = 1, e_a = 0, e_din = 0, e_done = 0;
        int last = 1, rd_p = 0, g;
        ev_t e;
        forever begin
            @(posedge clk);
            s_clr = clr; s_dout = pokey_dout;
            s_v0 = req0_valid; s_rw0 = req0_rw; s_a0 = req0_addr; s_d0 = req0_data;
            s_v1 = req1_valid; s_rw1 = req1_rw; s_a1 = req1_addr; s_d1 = req1_data;
            #1;
            if (s_clr) begin
                cyc = -1; last = 1; m_rd_pend = 0; exq.delete();
                e_cs0 = 1; e_rw = 1; e_a = 0; e_din = 0; e_done = 0;
            end else begin
                cyc++;
                if (cyc % P == 0) begin
                    if (m_rd_pend) begin
                        e.cyc = cyc; e.kind = 2; e.port = rd_p; e.data = int'(s_dout);
                        exq.push_back(e);
                        m_rd_pend = 0;
                    end
                    e_cs0 = 1; e_rw = 1;
                    if (cyc / P == 0) begin
                        e_cs0 = 0; e_rw = 0; e_a = 15; e_din = 8'h03;
                    end else if (cyc / P == 1) begin
                        e_cs0 = 0; e_rw = 0; e_a = 8; e_din = 8'h00;
                    end else begin
                        e_done = 1;
                        g = -1;
                        if (s_v0 && s_v1) g = 1 - last;
                        else if (s_v0) g = 0;
                        else if (s_v1) g = 1;
                        if (g >= 0) begin
                            last = g;
                            e.cyc = cyc; e.kind = g; e.port = g; e.data = 0;
                            exq.push_back(e);
                            e_cs0 = 0;
                            e_rw  = int'(g == 1 ? s_rw1 : s_rw0);
                            e_a   = int'(g == 1 ? s_a1 : s_a0);
                            e_din = int'(g == 1 ? s_d1 : s_d0);
                            if (e_rw == 1) begin m_rd_pend = 1; rd_p = g; end
                        end
                    end
                end
            end
            chk("cs0_bar", int'(pokey_cs0_bar), e_cs0);
            chk("phi2", int'(pokey_phi2), int'(cyc >= 0 && (cyc % P) >= PH));
            chk("rw", int'(pokey_rw), e_rw);
            chk("busy", int'(busy), 1 - e_cs0);
            chk("init_done", int'(init_done), e_done);
            if (e_cs0 == 0 || cyc < 0) begin
                chk("addr", int'(pokey_a), e_a);
                chk("din", int'(pokey_din), e_din);
            end
            if (cyc < 0) chk("rd_data_reset", int'(rd_data), 0);
        end
    end

    task automatic expect_ev(input int kind, input int port, input int data);
        ev_t e;
        nvec++;
        if (exq.size() == 0) begin
            nfail++;
            $display("FAIL unexpected_event cycle %0d: got kind %0d want none", cyc, kind);
        end else begin
            e = exq.pop_front();
            if (e.cyc != cyc || e.kind != kind || (kind == 2 && (e.port != port || e.data != data)))
            begin
                nfail++;
                $display("FAIL event cycle %0d: got kind %0d port %0d data %0h want cycle %0d kind %0d port %0d data %0h",
                         cyc, kind, port, data, e.cyc, e.kind, e.port, e.data);
            end
        end
    endtask

    // Monitor: runs after the model each cycle, consumes DUT handshake pulses.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            while (exq.size() > 0 && exq[0].cyc < cyc) begin
                nvec++; nfail++;
                $display("FAIL missed_event cycle %0d: got nothing want kind %0d at cycle %0d",
                         cyc, exq[0].kind, exq[0].cyc);
                exq.delete(0);
            end
            if (rd_valid)   expect_ev(2, int'(rd_port), int'(rd_data));
            if (req0_ready) expect_ev(0, 0, 0);
            if (req1_ready) expect_ev(1, 1, 0);
        end
    end

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || exq.size() != 0 || m_rd_pend) && n < budget)
        begin
            @(posedge clk);
            #3;
            n++;
        end
        if (n >= budget) begin
            nvec++; nfail++;
            $display("FAIL drain_timeout cycle %0d: got %0d pending want 0", cyc,
                     q0.size() + q1.size() + exq.size());
        end
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        // Init: port 0 read waits through both init writes; port 1 write then follows.
        push(0, 1'b1, 4'hA, 8'h00, 10);
        push(1, 1'b0, 4'h1, 8'hAF, 0);
        push(0, 1'b1, 4'hA, 8'h00, 0);
        drain(2000);
        // Contention: both ports always valid, grants must alternate.
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b0, 4'(i), 8'(8'h10 + i), 0);
            push(1, 1'b1, 4'(i + 4), 8'(8'h20 + i), 0);
        end
        drain(2000);
        // Random traffic with random gaps (late requests land mid-period).
        for (int i = 0; i < 30; i++) begin
            push(0, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), $urandom_range(0, 80));
            push(1, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), $urandom_range(0, 80));
        end
        drain(20000);
        // Reset in the middle of a port 0 read: read must be dropped, init must rerun.
        push(0, 1'b1, 4'h3, 8'h00, 0);
        n = 0;
        while (!req0_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) begin
            nvec++; nfail++;
            $display("FAIL ready_timeout cycle %0d: got 0 want 1", cyc);
        end
        repeat (39) @(posedge clk);
        #1;
        clr = 1'b1;
        push(1, 1'b0, 4'h3, 8'h77, 0);
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        drain(2000);
        repeat (2 * P) @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
